// File: rtl/key_event_pkg.sv
// Shared types for the key event controller: event encodings, FSM states,
// queue entry layout and counter width.
package key_event_pkg;

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned CODE_W = 5;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'b00,
    EV_REPEAT  = 2'b01,
    EV_RELEASE = 2'b10
  } ev_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HELD   = 2'b01,
    ST_REPEAT = 2'b10
  } state_e;

  // One queue entry: 2-bit type above 5-bit key code (7 bits total).
  typedef struct packed {
    ev_type_e            typ;
    logic [CODE_W-1:0]   code;
  } ev_t;

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event queue.
// Ports: clk, rst_n (async active-low); push_i/push_data_i write an entry,
// pop_i removes the head; rd_data_o is the head entry; full_o/empty_o/count_o
// report occupancy. Push and pop in the same cycle are both honoured, even
// when full.
module key_event_fifo
  import key_event_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  ev_t                    push_data_i,
  input  logic                   pop_i,
  output ev_t                    rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_FW = PTR_W + 1;

  ev_t               mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic              do_push, do_pop;

  assign full_o    = (count_q == CNT_FW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A pop frees the slot this cycle, so a push while full is still accepted.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_FW'(do_push) - CNT_FW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as PRESS/code 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Keypad event controller: turns a debounced single-key level into
// PRESS / REPEAT / RELEASE events queued for a consumer.
// Ports: clk, rst_n (async active-low); key_code/key_ready scanned key input;
// ev_valid/ev_code/ev_type head of event queue, ev_ready consumer accept;
// ovf sticky lost PRESS/RELEASE flag, ovf_clr synchronous clear.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter logic [CNT_W-1:0] REPEAT_DELAY  = 24'd5000000,
  parameter logic [CNT_W-1:0] REPEAT_PERIOD = 24'd1250000,
  parameter int unsigned      FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] key_code,
  input  logic              key_ready,
  output logic              ev_valid,
  output logic [CODE_W-1:0] ev_code,
  output logic [1:0]        ev_type,
  input  logic              ev_ready,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int unsigned CNT_FW = $clog2(FIFO_DEPTH) + 1;

  logic [CODE_W-1:0] k_code_q;
  logic              k_rdy_q;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] held_q, held_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  limit_c;
  logic              gen_c;
  ev_t               gen_ev_c;

  ev_t               head;
  logic              fifo_full, fifo_empty, pop, drop_counted;
  logic [CNT_FW-1:0] fifo_count;

  // Input capture: every decision below uses the registered copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_code_q <= '0;
      k_rdy_q  <= 1'b0;
    end else begin
      k_code_q <= key_code;
      k_rdy_q  <= key_ready;
    end
  end

  // Terminal count differs between first repeat and subsequent repeats.
  assign limit_c = (state_q == ST_HELD) ? (REPEAT_DELAY - CNT_W'(1))
                                        : (REPEAT_PERIOD - CNT_W'(1));

  // Next-state and event generation; release beats a repeat due this cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    held_d   = held_q;
    gen_c    = 1'b0;
    gen_ev_c = '{typ: EV_PRESS, code: k_code_q};
    case (state_q)
      ST_IDLE: begin
        if (k_rdy_q) begin
          gen_c    = 1'b1;
          gen_ev_c = '{typ: EV_PRESS, code: k_code_q};
          held_d   = k_code_q;
          cnt_d    = '0;
          state_d  = ST_HELD;
        end
      end
      ST_HELD, ST_REPEAT: begin
        if (!k_rdy_q || (k_code_q != held_q)) begin
          gen_c    = 1'b1;
          gen_ev_c = '{typ: EV_RELEASE, code: held_q};
          state_d  = ST_IDLE;
        end else if (cnt_q == limit_c) begin
          gen_c    = 1'b1;
          gen_ev_c = '{typ: EV_REPEAT, code: held_q};
          cnt_d    = '0;
          state_d  = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
    end
  end

  // Only lost PRESS/RELEASE events are reported; a lost REPEAT is harmless.
  assign pop          = ev_valid & ev_ready;
  assign drop_counted = gen_c & fifo_full & ~pop & (gen_ev_c.typ != EV_REPEAT);
  assign ovf_d        = drop_counted | (ovf_q & ~ovf_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (gen_c),
    .push_data_i (gen_ev_c),
    .pop_i       (pop),
    .rd_data_o   (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign ev_valid = ~fifo_empty;
  assign ev_code  = head.code;
  assign ev_type  = head.typ;
  assign ovf      = ovf_q;

  // Occupancy sanity: count agrees with empty and never exceeds the depth.
  count_ok_a: assert property (@(posedge clk) disable iff (!rst_n)
    (((fifo_count == '0) == fifo_empty) && (fifo_count <= CNT_FW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl (REPEAT_DELAY=8, REPEAT_PERIOD=4,
// FIFO_DEPTH=4): directed table, hand sequences, then randomized traffic
// against an event-level reference model.
module tb_key_event_ctrl;

  localparam int T_PRESS = 0;
  localparam int T_REP   = 1;
  localparam int T_REL   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] key_code;
  logic       key_ready;
  logic       ev_valid;
  logic [4:0] ev_code;
  logic [1:0] ev_type;
  logic       ev_ready;
  logic       ovf;
  logic       ovf_clr;

  int checks   = 0;
  int failures = 0;

  key_event_ctrl #(
    .REPEAT_DELAY  (24'd8),
    .REPEAT_PERIOD (24'd4),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_code  (key_code),
    .key_ready (key_ready),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .ev_type   (ev_type),
    .ev_ready  (ev_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic expect_head(input string name, input int code, input int typ);
    chk({name, "_valid"}, int'(ev_valid), 1);
    chk({name, "_code"}, int'(ev_code), code);
    chk({name, "_type"}, int'(ev_type), typ);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    key_ready = 1'b0;
    key_code  = 5'h00;
    ev_ready  = 1'b1;
    ovf_clr   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       kr;
    logic [4:0] kc;
    logic       ev;
    logic [1:0] et;
    logic [4:0] ec;
  } vec_t;

  localparam int NVEC = 40;
  vec_t tbl[NVEC];

  // Reference model state (random phase)
  logic [6:0] mq[$];
  bit         hv;
  logic [4:0] hc;
  int         age;
  logic       m_kr;
  logic [4:0] m_kc;
  logic       m_ovf;

  initial begin
    // Table: entry i = inputs driven and outputs expected at negedge i.
    for (int i = 0; i < NVEC; i++) tbl[i] = '{kr: 1'b0, kc: 5'h06, ev: 1'b0, et: 2'd0, ec: 5'h00};
    for (int i = 0; i < 20; i++) tbl[i].kr = 1'b1;
    tbl[2]  = '{kr: 1'b1, kc: 5'h06, ev: 1'b1, et: 2'(T_PRESS), ec: 5'h06};
    tbl[10] = '{kr: 1'b1, kc: 5'h06, ev: 1'b1, et: 2'(T_REP),   ec: 5'h06};
    tbl[14] = '{kr: 1'b1, kc: 5'h06, ev: 1'b1, et: 2'(T_REP),   ec: 5'h06};
    tbl[18] = '{kr: 1'b1, kc: 5'h06, ev: 1'b1, et: 2'(T_REP),   ec: 5'h06};
    tbl[22] = '{kr: 1'b0, kc: 5'h06, ev: 1'b1, et: 2'(T_REL),   ec: 5'h06};
    for (int i = 24; i <= 32; i++) begin
      tbl[i].kr = 1'b1;
      tbl[i].kc = (i < 28) ? 5'h06 : 5'h11;
    end
    tbl[26].ev = 1'b1; tbl[26].et = 2'(T_PRESS); tbl[26].ec = 5'h06;
    tbl[30].ev = 1'b1; tbl[30].et = 2'(T_REL);   tbl[30].ec = 5'h06;
    tbl[31].ev = 1'b1; tbl[31].et = 2'(T_PRESS); tbl[31].ec = 5'h11;
    tbl[35].ev = 1'b1; tbl[35].et = 2'(T_REL);   tbl[35].ec = 5'h11;

    // Reset values
    do_reset();
    chk("rst_valid", int'(ev_valid), 0);
    chk("rst_code", int'(ev_code), 0);
    chk("rst_type", int'(ev_type), T_PRESS);
    chk("rst_ovf", int'(ovf), 0);

    // Press / repeat / release and code switch
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), int'(ev_valid), int'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_code", i), int'(ev_code), int'(tbl[i].ec));
        chk($sformatf("tbl%0d_type", i), int'(ev_type), int'(tbl[i].et));
      end
      chk($sformatf("tbl%0d_ovf", i), int'(ovf), 0);
      key_ready = tbl[i].kr;
      key_code  = tbl[i].kc;
    end

    // Overflow: five events into a 4-deep queue with no consumer
    do_reset();
    ev_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      key_code  = 5'(6 + j);
      key_ready = 1'b1;
      repeat (3) @(negedge clk);
      if (j < 2) begin
        key_ready = 1'b0;
        repeat (3) @(negedge clk);
      end
    end
    chk("ovf_valid", int'(ev_valid), 1);
    chk("ovf_set", int'(ovf), 1);
    repeat (10) @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", int'(ovf), 0);
    repeat (5) @(negedge clk);
    chk("ovf_repeat_drop_silent", int'(ovf), 0);
    ev_ready = 1'b1;
    expect_head("drain0", 5'h06, T_PRESS);
    @(negedge clk);
    expect_head("drain1", 5'h06, T_REL);
    @(negedge clk);
    expect_head("drain2", 5'h07, T_PRESS);
    @(negedge clk);
    expect_head("drain3", 5'h07, T_REL);
    key_ready = 1'b0;
    repeat (10) @(negedge clk);

    // Full queue with simultaneous pop and push
    do_reset();
    ev_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      key_code  = 5'(6 + j);
      key_ready = 1'b1;
      repeat (3) @(negedge clk);
      key_ready = 1'b0;
      repeat (3) @(negedge clk);
    end
    chk("full_valid", int'(ev_valid), 1);
    chk("full_ovf", int'(ovf), 0);
    key_code  = 5'h08;
    key_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    chk("pushpop_ovf", int'(ovf), 0);
    expect_head("pp0", 5'h06, T_REL);
    @(negedge clk);
    expect_head("pp1", 5'h07, T_PRESS);
    @(negedge clk);
    expect_head("pp2", 5'h07, T_REL);
    @(negedge clk);
    expect_head("pp3", 5'h08, T_PRESS);
    @(negedge clk);
    chk("pp_empty", int'(ev_valid), 0);

    // Asynchronous reset while a key is in auto-repeat
    do_reset();
    ev_ready = 1'b0;
    key_code = 5'h03;
    key_ready = 1'b1;
    repeat (14) @(negedge clk);
    chk("pre_rst_valid", int'(ev_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(ev_valid), 0);
    chk("async_rst_code", int'(ev_code), 0);
    chk("async_rst_type", int'(ev_type), T_PRESS);
    chk("async_rst_ovf", int'(ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ev_ready = 1'b1;
    chk("post_rst0_valid", int'(ev_valid), 0);
    @(negedge clk);
    chk("post_rst1_valid", int'(ev_valid), 0);
    @(negedge clk);
    expect_head("post_rst_press", 5'h03, T_PRESS);
    @(negedge clk);
    chk("post_rst_no_release", int'(ev_valid), 0);

    // Randomized traffic against the event-level model
    do_reset();
    mq.delete();
    hv = 0; hc = '0; age = 0; m_kr = 1'b0; m_kc = '0; m_ovf = 1'b0;
    begin
      int er_pct;
      er_pct = 20;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        bit         gen, full, pop, drop;
        logic [1:0] gt;
        logic [4:0] gc;
        @(negedge clk);
        chk("rnd_valid", int'(ev_valid), int'(mq.size() != 0));
        if (mq.size() != 0) begin
          chk("rnd_code", int'(ev_code), int'(mq[0][4:0]));
          chk("rnd_type", int'(ev_type), int'(mq[0][6:5]));
        end
        chk("rnd_ovf", int'(ovf), int'(m_ovf));

        if (cyc % 200 == 0) er_pct = ((cyc / 200) % 2 != 0) ? 90 : 20;
        if ($urandom_range(0, 11) == 0) key_ready = ~key_ready;
        if ($urandom_range(0, 19) == 0) key_code = 5'($urandom);
        ev_ready = ($urandom_range(0, 99) < er_pct);
        ovf_clr  = ($urandom_range(0, 19) == 0);

        // Events follow from press age: first repeat 8 cycles after the
        // press, then every 4; release wins whenever the key changes.
        gen = 0; gt = 2'(T_PRESS); gc = '0;
        if (!hv) begin
          if (m_kr) begin
            gen = 1; gt = 2'(T_PRESS); gc = m_kc;
            hv = 1; hc = m_kc; age = 0;
          end
        end else begin
          age++;
          if (!m_kr || (m_kc != hc)) begin
            gen = 1; gt = 2'(T_REL); gc = hc; hv = 0;
          end else if (age >= 8 && ((age - 8) % 4) == 0) begin
            gen = 1; gt = 2'(T_REP); gc = hc;
          end
        end
        full = (mq.size() == 4);
        pop  = (mq.size() != 0) && ev_ready;
        drop = 0;
        if (pop) void'(mq.pop_front());
        if (gen) begin
          if (!full || pop) mq.push_back({gt, gc});
          else drop = 1;
        end
        if (drop && gt != 2'(T_REP)) m_ovf = 1'b1;
        else if (ovf_clr)            m_ovf = 1'b0;
        m_kr = key_ready;
        m_kc = key_code;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
